// File: rtl/wdog_rst_pkg.sv
// Shared types and constants for the watchdog reset controller.
// The FSM encoding is also visible on the top-level debug output.
package wdog_rst_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ASSERT  = 2'd1,
        RELEASE = 2'd2
    } state_e;

    localparam int CAUSE_INT  = 0;
    localparam int CAUSE_WDOG = 1;
    localparam int CAUSE_SW   = 2;

endpackage

// File: rtl/edge_rise_det.sv
// Rising-edge detector: registers the previous sample, and the pulse is
// combinational so a rise is acted on in the same cycle it appears.
module edge_rise_det (
    input  logic clk_i,
    input  logic rst_i,
    input  logic d_i,
    output logic rise_o
);

    logic d_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            d_q <= 1'b0;
        end else begin
            d_q <= d_i;
        end
    end

    assign rise_o = d_i & ~d_q;

endmodule

// File: rtl/wdog_rst_ctrl.sv
// Stretches watchdog/software reset requests into a fixed-length system reset,
// keeps the watchdog itself in reset a little longer, and records reset causes.
module wdog_rst_ctrl
    import wdog_rst_pkg::*;
#(
    parameter int RST_HOLD_CYCLES = 16,
    parameter int WDOG_RST_DELAY  = 4,
    parameter int CNT_W           = 8
) (
    input  logic             PCLK,
    input  logic             PRESET,
    input  logic             watchdog_int,
    input  logic             watchdog_res,
    input  logic             sw_rst_req,
    input  logic             clr_cause,
    output logic             sys_rst_req,
    output logic             watchdog_rstn,
    output logic             busy,
    output logic [2:0]       rst_cause,
    output logic [CNT_W-1:0] rst_count,
    output logic [1:0]       dbg_state
);

    localparam int HOLD_MAX = (RST_HOLD_CYCLES > WDOG_RST_DELAY) ? RST_HOLD_CYCLES : WDOG_RST_DELAY;
    localparam int HOLD_W   = $clog2(HOLD_MAX) + 1;
    localparam logic [HOLD_W-1:0] HOLD_LOAD  = HOLD_W'(RST_HOLD_CYCLES - 1);
    localparam logic [HOLD_W-1:0] DELAY_LOAD = HOLD_W'(WDOG_RST_DELAY - 1);
    localparam logic [CNT_W-1:0]  CNT_MAX    = '1;

    state_e            state_q;
    logic [HOLD_W-1:0] hold_q;
    logic              sys_rst_q;
    logic              wdog_rstn_q;
    logic              busy_q;
    logic [2:0]        cause_q;
    logic [2:0]        cause_d;
    logic [CNT_W-1:0]  count_q;
    logic [CNT_W-1:0]  count_d;
    logic              res_rise;
    logic              int_rise;
    logic              start;

    edge_rise_det u_res_edge (
        .clk_i  (PCLK),
        .rst_i  (PRESET),
        .d_i    (watchdog_res),
        .rise_o (res_rise)
    );

    edge_rise_det u_int_edge (
        .clk_i  (PCLK),
        .rst_i  (PRESET),
        .d_i    (watchdog_int),
        .rise_o (int_rise)
    );

    // Requests are only accepted from IDLE; a set event beats a same-cycle clear.
    always_comb begin
        start   = (state_q == IDLE) && (res_rise || sw_rst_req);
        cause_d = clr_cause ? 3'b000 : cause_q;
        if (int_rise) cause_d[CAUSE_INT] = 1'b1;
        if (start && res_rise) cause_d[CAUSE_WDOG] = 1'b1;
        if (start && sw_rst_req) cause_d[CAUSE_SW] = 1'b1;
        count_d = count_q;
        if (start && (count_q != CNT_MAX)) count_d = count_q + 1'b1;
    end

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            state_q     <= IDLE;
            hold_q      <= '0;
            sys_rst_q   <= 1'b0;
            wdog_rstn_q <= 1'b0;
            busy_q      <= 1'b0;
            cause_q     <= '0;
            count_q     <= '0;
        end else begin
            cause_q <= cause_d;
            count_q <= count_d;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_q     <= ASSERT;
                        hold_q      <= HOLD_LOAD;
                        sys_rst_q   <= 1'b1;
                        wdog_rstn_q <= 1'b0;
                        busy_q      <= 1'b1;
                    end else begin
                        sys_rst_q   <= 1'b0;
                        wdog_rstn_q <= 1'b1;
                        busy_q      <= 1'b0;
                    end
                end
                ASSERT: begin
                    if (hold_q == '0) begin
                        state_q   <= RELEASE;
                        hold_q    <= DELAY_LOAD;
                        sys_rst_q <= 1'b0;
                    end else begin
                        hold_q <= hold_q - 1'b1;
                    end
                end
                RELEASE: begin
                    if (hold_q == '0) begin
                        state_q     <= IDLE;
                        wdog_rstn_q <= 1'b1;
                        busy_q      <= 1'b0;
                    end else begin
                        hold_q <= hold_q - 1'b1;
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    sys_rst_q   <= 1'b0;
                    wdog_rstn_q <= 1'b1;
                    busy_q      <= 1'b0;
                end
            endcase
        end
    end

    assign sys_rst_req   = sys_rst_q;
    assign watchdog_rstn = wdog_rstn_q;
    assign busy          = busy_q;
    assign rst_cause     = cause_q;
    assign rst_count     = count_q;
    assign dbg_state     = state_q;

endmodule

// File: doc/wdog_rst_ctrl.md
Name: wdog_rst_ctrl

Overview:
- Reset/interrupt controller directly downstream of the watchdog peripheral.
- Consumes watchdog_int and watchdog_res; generates a stretched system reset request.
- Drives the watchdog's own watchdog_rstn, so the watchdog is held in reset through and after the system reset.
- Keeps sticky reset-cause flags and a saturating reset counter for software diagnosis.

Parameters:
RST_HOLD_CYCLES, 16, cycles sys_rst_req stays high per event (>=1)
WDOG_RST_DELAY, 4, extra cycles watchdog_rstn stays low after sys_rst_req falls (>=1)
CNT_W, 8, width of rst_count

Ports:
PCLK  input  1  clock; all logic on rising edge
PRESET  input  1  synchronous, active-high reset
watchdog_int  input  1  watchdog interrupt, level
watchdog_res  input  1  watchdog reset request, level
sw_rst_req  input  1  software reset request, single-cycle pulse
clr_cause  input  1  clear cause flags, single-cycle pulse
sys_rst_req  output  1  stretched system reset request, active-high
watchdog_rstn  output  1  reset to watchdog, active-low
busy  output  1  high whenever FSM is not IDLE
rst_cause  output  3  sticky: [0] watchdog_int seen, [1] watchdog reset, [2] software reset
rst_count  output  CNT_W  number of reset sequences started, saturating

Behaviour:
- One clock, PCLK. Reset is synchronous and active-high on PRESET. All outputs registered.
- Reset values: sys_rst_req=0, watchdog_rstn=0, busy=0, rst_cause=0, rst_count=0, FSM=IDLE, edge regs=0, hold counter=0.
- First cycle after PRESET deasserts: IDLE drives watchdog_rstn=1.
- Edge detect: res_q/int_q hold the previous-cycle samples.
  - res_rise = watchdog_res & ~res_q.
  - int_rise = watchdog_int & ~int_q.
  - A level held high never re-triggers.
- IDLE: sys_rst_req=0, watchdog_rstn=1, busy=0.
  - On (res_rise | sw_rst_req) in cycle N: go to ASSERT; load hold counter with RST_HOLD_CYCLES-1.
  - In cycle N+1: sys_rst_req=1, watchdog_rstn=0, busy=1.
- ASSERT: sys_rst_req high for exactly RST_HOLD_CYCLES cycles.
  - Counter decrements each cycle.
  - When counter==0: go to RELEASE; load counter with WDOG_RST_DELAY-1.
- RELEASE: sys_rst_req=0, watchdog_rstn=0, busy=1 for exactly WDOG_RST_DELAY cycles.
  - When counter==0: go to IDLE; watchdog_rstn returns to 1 the following cycle.
- res_rise or sw_rst_req while in ASSERT/RELEASE: ignored. No restart, no count, no cause update.
- Cause flags:
  - int_rise sets [0] in any state.
  - Accepted res_rise sets [1].
  - Accepted sw_rst_req sets [2].
  - clr_cause clears all three. Any set event in the same cycle wins for its own bit.
- Simultaneous res_rise and sw_rst_req in IDLE: one sequence, both [1] and [2] set, rst_count +1.
- rst_count increments by 1 on each accepted entry to ASSERT; saturates at 2^CNT_W-1 (no wrap).
- sys_rst_req does not clear this block's state. Only PRESET does.
- PRESET asserted mid-sequence: next edge returns all state to reset values, aborting the sequence.

Decomposition:
- Shared package wdog_rst_pkg holds:
  - FSM enum state_e {IDLE, ASSERT, RELEASE};
  - cause bit index constants CAUSE_INT=0, CAUSE_WDOG=1, CAUSE_SW=2.
- One sub-module edge_rise_det (registered rising-edge detector), instantiated twice (res, int).
- The hold counter stays inline. Its width is $clog2 of the larger of RST_HOLD_CYCLES and WDOG_RST_DELAY, plus 1.

Test Plan:
- Watchdog reset event (defaults): PRESET released, then watchdog_res rises at cycle 10 -> sys_rst_req=1 cycles 11-26; watchdog_rstn=0 cycles 11-30, then 1 from cycle 31; rst_cause=3'b010; rst_count=1.
- Held level: watchdog_res held high 100 cycles -> exactly one sequence; rst_count=1.
- Software request and simultaneity: sw_rst_req pulse -> rst_cause[2]=1. sw_rst_req and res_rise together -> single 16-cycle sequence, rst_cause=3'b110, rst_count +1. Second sw_rst_req during RELEASE -> ignored.
- Interrupt and clear: watchdog_int rises -> rst_cause[0]=1, no reset. clr_cause in the same cycle as a new int_rise -> rst_cause[0] stays 1. clr_cause alone -> rst_cause=0.
- Abort and saturation: PRESET asserted at hold cycle 5 -> next cycle all outputs at reset values (watchdog_rstn=0), then watchdog_rstn=1 after release. With CNT_W=2, five events -> rst_count=3.
